// File: rtl/pixel_fill_engine.sv
// pixel_fill_engine: clipped rectangle fill into the framebuffer SRAM write FIFO
module pixel_fill_engine #(
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic [8:0]  cmd_x,
    input  logic [7:0]  cmd_y,
    input  logic [8:0]  cmd_w,
    input  logic [7:0]  cmd_h,
    input  logic [7:0]  cmd_color,
    input  logic        cmd_blank_only,
    input  logic        abort,
    input  logic        blank,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [16:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, CLIP, RUN, FINISH} state_t;

    localparam logic [9:0]  FBW  = 10'(FB_WIDTH);
    localparam logic [8:0]  FBH  = 9'(FB_HEIGHT);
    localparam logic [16:0] STEP = 17'(FB_WIDTH);

    state_t      state, state_n;
    logic [8:0]  x_q, w_q, w_eff, w_eff_n, col, col_n;
    logic [7:0]  y_q, h_q, h_eff, h_eff_n, row, row_n, color_q;
    logic        blank_only_q;
    logic [16:0] row_base, row_base_n;
    logic [9:0]  x_room, w_clip;
    logic [8:0]  y_room, h_clip;
    logic        off_screen, hs, last_col, last_row;

    assign x_room     = FBW - {1'b0, x_q};
    assign w_clip     = ({1'b0, w_q} < x_room) ? {1'b0, w_q} : x_room;
    assign y_room     = FBH - {1'b0, y_q};
    assign h_clip     = ({1'b0, h_q} < y_room) ? {1'b0, h_q} : y_room;
    assign off_screen = ({1'b0, x_q} >= FBW) || ({1'b0, y_q} >= FBH) || (w_clip == 10'd0) || (h_clip == 9'd0);

    assign wr_valid = (state == RUN) && !abort && (!blank_only_q || blank);
    assign hs       = wr_valid && wr_ready;
    assign last_col = col == w_eff - 9'd1;
    assign last_row = row == h_eff - 8'd1;
    assign wr_addr  = row_base + {8'd0, x_q} + {8'd0, col};
    assign wr_data  = color_q;
    assign busy     = state != IDLE;
    assign done     = state == FINISH;

    // State, command latch and raster position registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            w_q          <= '0;
            h_q          <= '0;
            color_q      <= '0;
            blank_only_q <= 1'b0;
            w_eff        <= '0;
            h_eff        <= '0;
            col          <= '0;
            row          <= '0;
            row_base     <= '0;
        end else begin
            state    <= state_n;
            w_eff    <= w_eff_n;
            h_eff    <= h_eff_n;
            col      <= col_n;
            row      <= row_n;
            row_base <= row_base_n;
            if (state == IDLE && cmd_start) begin
                x_q          <= cmd_x;
                y_q          <= cmd_y;
                w_q          <= cmd_w;
                h_q          <= cmd_h;
                color_q      <= cmd_color;
                blank_only_q <= cmd_blank_only;
            end
        end
    end

    // Next state: clip once, then raster-walk the rectangle one handshake at a time
    always_comb begin
        state_n    = state;
        w_eff_n    = w_eff;
        h_eff_n    = h_eff;
        col_n      = col;
        row_n      = row;
        row_base_n = row_base;
        case (state)
            IDLE: if (cmd_start) state_n = CLIP;
            CLIP: begin
                if (abort || off_screen) begin
                    state_n = FINISH;
                end else begin
                    state_n    = RUN;
                    w_eff_n    = w_clip[8:0];
                    h_eff_n    = h_clip[7:0];
                    col_n      = '0;
                    row_n      = '0;
                    row_base_n = ({9'd0, y_q} << 8) + ({9'd0, y_q} << 6);
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = FINISH;
                end else if (hs) begin
                    if (last_col) begin
                        col_n      = '0;
                        row_n      = row + 8'd1;
                        row_base_n = row_base + STEP;
                        if (last_row) state_n = FINISH;
                    end else begin
                        col_n = col + 9'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pixel_fill_engine.sv
// tb_pixel_fill_engine: randomized fills checked against an address-list model
module tb_pixel_fill_engine;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_start = 1'b0;
    logic [8:0]  cmd_x = '0;
    logic [7:0]  cmd_y = '0;
    logic [8:0]  cmd_w = '0;
    logic [7:0]  cmd_h = '0;
    logic [7:0]  cmd_color = '0;
    logic        cmd_blank_only = 1'b0;
    logic        abort = 1'b0;
    logic        blank = 1'b0;
    logic        wr_ready = 1'b1;
    logic        wr_valid, busy, done;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int exp_q[$];
    int exp_col = 0;
    bit exp_bo = 0;
    int writes = 0;
    int done_seen = 0;
    int done_cyc = -1;
    int first_v = -1;
    int start_cyc = 0;
    int abort_cyc = -1;
    bit prev_stall = 0;
    int prev_addr = 0;

    pixel_fill_engine dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color), .cmd_blank_only(cmd_blank_only),
        .abort(abort), .blank(blank), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected write list: every on-screen pixel of the rectangle in raster order
    function automatic void build_q(input int x, input int y, input int w, input int h);
        int we, he;
        exp_q.delete();
        we = (x >= 320) ? 0 : ((w < 320 - x) ? w : 320 - x);
        he = (y >= 240) ? 0 : ((h < 240 - y) ? h : 240 - y);
        for (int r = 0; r < he; r++)
            for (int c = 0; c < we; c++)
                exp_q.push_back((y + r) * 320 + x + c);
    endfunction

    // Per-cycle compare of the write port against the expected list
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_valid) begin
                if (first_v < 0) first_v = cyc;
                if (exp_q.size() == 0) chk("unexpected_write", int'(wr_addr), -1);
                else chk("addr", int'(wr_addr), exp_q[0]);
                chk("data", int'(wr_data), exp_col);
                if (exp_bo) chk("blank_gate", int'(blank), 1);
                if (prev_stall) chk("hold_addr", int'(wr_addr), prev_addr);
                if (wr_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    writes++;
                end
            end
            prev_stall = wr_valid && !wr_ready;
            prev_addr = int'(wr_addr);
            if (done) begin
                done_seen++;
                done_cyc = cyc;
            end
        end else begin
            prev_stall = 0;
        end
    end

    task automatic start_cmd(input int x, input int y, input int w, input int h, input int c, input bit bo);
        build_q(x, y, w, h);
        exp_col = c;
        exp_bo = bo;
        writes = 0;
        done_seen = 0;
        done_cyc = -1;
        first_v = -1;
        abort_cyc = -1;
        @(posedge clk); #1;
        cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h);
        cmd_color = 8'(c); cmd_blank_only = bo; cmd_start = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic run_cmd(input int x, input int y, input int w, input int h, input int c,
                           input bit bo, input int low_pct, input int abort_after, input bit mid_start);
        int n;
        bit aborted;
        aborted = 0;
        start_cmd(x, y, w, h, c, bo);
        n = exp_q.size();
        for (int i = 0; i < 5000 && done_seen == 0; i++) begin
            @(posedge clk); #1;
            cmd_start = 1'b0;
            abort = 1'b0;
            wr_ready = (low_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= low_pct);
            blank = bo ? 1'((cyc / 7) % 2) : 1'($urandom_range(0, 1));
            if (abort_after > 0 && !aborted && writes == abort_after) begin
                abort = 1'b1;
                aborted = 1;
                abort_cyc = cyc;
            end
            if (mid_start && writes == 2) begin
                cmd_x = 9'd0; cmd_y = 8'd0; cmd_w = 9'd5; cmd_h = 8'd5; cmd_color = 8'h11;
                cmd_start = 1'b1;
            end
        end
        chk("done_seen", done_seen, 1);
        chk("busy_after_done", int'(busy), 0);
        abort = 1'b0;
        cmd_start = 1'b0;
        wr_ready = 1'b1;
        if (aborted) begin
            chk("abort_writes", writes, abort_after);
            chk("abort_done_latency", done_cyc, abort_cyc + 1);
        end else begin
            chk("write_count", writes, n);
            chk("all_written", exp_q.size(), 0);
            if (low_pct == 0 && !bo) begin
                chk("total_cycles", done_cyc - start_cyc + 1, n + 3);
                if (n > 0) chk("first_valid", first_v, start_cyc + 2);
            end
        end
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #12;
        chk("rst_valid", int'(wr_valid), 0);
        chk("rst_addr", int'(wr_addr), 0);
        chk("rst_data", int'(wr_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;

        build_q(10, 5, 4, 2);
        chk("model_first", exp_q[0], 1610);
        chk("model_row2", exp_q[4], 1930);
        chk("model_size", exp_q.size(), 8);
        run_cmd(10, 5, 4, 2, 8'hE0, 0, 0, 0, 0);
        chk("basic_writes", writes, 8);
        chk("basic_cycles", done_cyc - start_cyc + 1, 11);

        build_q(318, 239, 10, 10);
        chk("model_clip_n", exp_q.size(), 2);
        chk("model_clip_last", exp_q[1], 76799);
        run_cmd(318, 239, 10, 10, 8'h1C, 0, 0, 0, 0);
        chk("clip_writes", writes, 2);

        run_cmd(320, 10, 5, 5, 8'h03, 0, 0, 0, 0);
        chk("offscreen_writes", writes, 0);
        chk("offscreen_cycles", done_cyc - start_cyc + 1, 3);

        run_cmd(40, 100, 0, 5, 8'h03, 0, 0, 0, 0);
        chk("zero_w_writes", writes, 0);

        run_cmd(7, 20, 16, 3, 8'h5A, 0, 40, 0, 0);
        chk("bp_writes", writes, 48);

        run_cmd(200, 200, 9, 4, 8'hA5, 1, 20, 0, 0);
        chk("blank_writes", writes, 36);

        run_cmd(100, 50, 20, 1, 8'hC3, 0, 0, 5, 1);

        for (int k = 0; k < 8; k++)
            run_cmd($urandom_range(0, 340), $urandom_range(0, 250), $urandom_range(0, 40),
                    $urandom_range(0, 6), $urandom_range(0, 255), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 50), 0, 0);

        start_cmd(30, 60, 30, 2, 8'h77, 0);
        for (int i = 0; i < 200 && writes < 3; i++) begin
            @(posedge clk); #1;
            cmd_start = 1'b0;
        end
        chk("pre_reset_writes", writes, 3);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_valid", int'(wr_valid), 0);
        chk("areset_busy", int'(busy), 0);
        chk("areset_done", int'(done), 0);
        @(posedge clk); #1;
        chk("reset_hold_done", int'(done), 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        chk("no_done_on_reset", done_seen, 0);
        run_cmd(0, 0, 3, 3, 8'h42, 0, 0, 0, 0);
        chk("post_reset_writes", writes, 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
